multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 op  in  6  opcode from instruction register, bits [31:26].
REQ-005 mem_ready  in  1  memory handshake; access completes in a cycle where mem_ready=1.
REQ-006 pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write  out  1 each  datapath strobes and selects.
REQ-007 mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  register-file and ALU-input selects.
REQ-008 alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-009 alu_op  out  2  00=add, 01=sub, 10=funct-decoded.
REQ-010 pc_source  out  2  00=ALU result, 01=ALUOut register, 10=jump target.
REQ-011 illegal_op  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-012 The block SHALL be a Moore FSM: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP, plus ADDI_EXEC and ADDI_WB when configured.
REQ-013 FETCH SHALL assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, and ir_write plus pc_write only in cycles where mem_ready=1.
REQ-014 FETCH SHALL hold while mem_ready=0 and SHALL go to DECODE on the cycle mem_ready=1.
REQ-015 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, then branch by op: 0x00->EXEC, 0x23/0x2B->MEM_ADDR, 0x04->BRANCH, 0x02->JUMP, anything else->FETCH with illegal_op=1 for that cycle.
REQ-016 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD for 0x23 or MEM_WR for 0x2B.
REQ-017 MEM_RD SHALL assert mem_read and i_or_d=1, hold until mem_ready=1, then go to MEM_WB.
REQ-018 MEM_WR SHALL assert mem_write and i_or_d=1, hold until mem_ready=1, then go to FETCH.
REQ-019 MEM_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-020 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB.
REQ-021 R_WB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-022 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-023 JUMP SHALL assert pc_write with pc_source=10, then go to FETCH.
REQ-024 Every output not named for a state SHALL be 0 in that state.
REQ-025 With mem_ready=1 throughout, instruction latency SHALL be: lw 5 cycles, sw 4, R-type 4, beq 3, j 3.
REQ-026 mem_write and reg_write SHALL never be asserted in the same cycle.
REQ-027 mem_read and mem_write SHALL never be asserted in the same cycle.

Reset
REQ-028 rst=1 at a clock edge SHALL force state to FETCH from any state, including mid-access wait in MEM_RD or MEM_WR.
REQ-029 While rst=1, all outputs SHALL be 0, including ir_write, pc_write and illegal_op.
REQ-030 On the first edge after rst falls, the block SHALL be in FETCH.

Configuration
REQ-031 Macro MULTICYCLE_ADDI_EN defined: op 0x08 in DECODE SHALL go to ADDI_EXEC.
REQ-032 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDI_WB.
REQ-033 ADDI_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-034 Macro MULTICYCLE_ADDI_EN undefined: op 0x08 SHALL be illegal per REQ-015, and ADDI states SHALL not exist.

Structure
REQ-035 Shared package mips_pkg SHALL hold opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), the ALU-op and pc_source encodings, and the state enum.
REQ-036 The block SHALL be a single module with a state register, next-state logic and output decode; no sub-module is required.

Verification
REQ-037 rst=1 for 2 cycles then release, op=0x00, mem_ready=1 -> states FETCH,DECODE,EXEC,R_WB,FETCH; reg_write=1 only in cycle 4 with reg_dst=1.
REQ-038 op=0x23, mem_ready held 0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1 and i_or_d=1; MEM_WB follows; total 8 cycles.
REQ-039 op=0x2B, mem_ready=1 -> mem_write=1 only in cycle 4, reg_write never asserted; op=0x04 -> pc_write_cond=1 and alu_op=01 in cycle 3.
REQ-040 op=0x3F -> illegal_op=1 in DECODE only, FETCH next cycle, no write strobes asserted.
REQ-041 rst asserted during MEM_WR wait (mem_ready=0) -> all outputs 0 in the reset cycle, FETCH afterwards, no mem_write after release.
REQ-042 op=0x08 -> with MULTICYCLE_ADDI_EN, reg_write=1 in cycle 4 with alu_src_b=10 in cycle 3; without it, illegal_op=1 in DECODE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/PC selects, FSM states.
// ADDI states exist only when MULTICYCLE_ADDI_EN is defined.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC,
    S_R_WB,
    S_BRANCH,
    S_JUMP
`ifdef MULTICYCLE_ADDI_EN
    ,
    S_ADDI_EXEC,
    S_ADDI_WB
`endif
  } state_t;

endpackage

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS datapath with a mem_ready handshake.
// Define MULTICYCLE_ADDI_EN to add the ADDI_EXEC/ADDI_WB path for opcode 0x08.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PC_ALU;
    illegal_op    = 1'b0;

    // Reset blanks every strobe, even in the cycle the state is being forced back to FETCH.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          case (op)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_ALUOUT;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_JUMP;
          state_d   = S_FETCH;
        end
`ifdef MULTICYCLE_ADDI_EN
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
